// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle between a requester and the bit-serial adder
interface serial_adder_if #(
    parameter int N = 8
) ();
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, S, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, S, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder: one full-adder cell, one carry flop, LSB first
module serial_adder #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic [N-1:0]   s_sh;
    logic [N-1:0]   s_q;
    logic           carry;
    logic           cout_q;
    logic [CW-1:0]  cnt;

    logic           sum_bit;
    logic           carry_nx;
    logic [N-1:0]   s_nx;
    logic           last;

    // Single full-adder cell on the current LSB pair plus stored carry
    always_comb begin
        sum_bit  = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        s_nx     = s_sh >> 1;
        s_nx[N-1] = sum_bit;
        last     = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            s_q    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        carry <= bus.Cin;
                        s_sh  <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_nx;
                    s_sh  <= s_nx;
                    cnt   <= cnt + CW'(1);
                    // Published result only moves on the final bit, so S/Cout hold through RUN
                    if (last) begin
                        s_q    <= s_nx;
                        cout_q <= carry_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at N=8 and N=1
module tb_serial_adder;
    logic clk;
    logic rst_n;

    serial_adder_if #(.N(8)) bus8 ();
    serial_adder_if #(.N(1)) bus1 ();

    serial_adder #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.N(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] prev_s = 8'h00;
    logic       prev_c = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int sum;
        sum = int'(a) + int'(b) + int'(c);
        return 9'(sum % 512);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
        logic [8:0] exp;
        exp = ref8(a, b, c);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.A = a;
        bus8.B = b;
        bus8.Cin = c;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.A = 8'($urandom);
        bus8.B = 8'($urandom);
        bus8.Cin = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, " busy"}, 64'(bus8.busy), 64'd1);
            check({tag, " done low in run"}, 64'(bus8.done), 64'd0);
            check({tag, " S holds"}, 64'(bus8.S), 64'(prev_s));
            check({tag, " Cout holds"}, 64'(bus8.Cout), 64'(prev_c));
        end
        @(negedge clk);
        check({tag, " done"}, 64'(bus8.done), 64'd1);
        check({tag, " busy low in done"}, 64'(bus8.busy), 64'd0);
        check({tag, " S"}, 64'(bus8.S), 64'(exp[7:0]));
        check({tag, " Cout"}, 64'(bus8.Cout), 64'(exp[8]));
        prev_s = exp[7:0];
        prev_c = exp[8];
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(bus8.done), 64'd0);
        check({tag, " idle busy"}, 64'(bus8.busy), 64'd0);
    endtask

    initial begin
        logic [7:0] xa1, xb1, xa2, xb2, xa3, xb3;
        logic       xc1, xc2, xc3;
        logic [8:0] r1, r3;
        logic [1:0] e1;
        logic       a1, b1, c1;
        int         dones;
        int         done_at;

        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
        bus1.start = 1'b0; bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus8.busy), 64'd0);
        check("reset done", 64'(bus8.done), 64'd0);
        check("reset S", 64'(bus8.S), 64'd0);
        check("reset Cout", 64'(bus8.Cout), 64'd0);
        check("reset n1 busy", 64'(bus1.busy), 64'd0);
        check("reset n1 done", 64'(bus1.done), 64'd0);
        rst_n = 1'b1;

        run8(8'h00, 8'h00, 1'b0, "zero");
        run8(8'hFF, 8'h01, 1'b0, "ff+01");
        run8(8'hA5, 8'h5A, 1'b1, "a5+5a+1");
        run8(8'h3C, 8'h42, 1'b0, "3c+42");
        for (int t = 0; t < 20; t++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), "random");
        end

        // Extra start pulses during RUN and DONE must be dropped
        xa1 = 8'($urandom); xb1 = 8'($urandom); xc1 = 1'($urandom);
        xa2 = ~xa1;         xb2 = ~xb1;         xc2 = ~xc1;
        xa3 = 8'($urandom); xb3 = 8'($urandom); xc3 = 1'($urandom);
        r1 = ref8(xa1, xb1, xc1);
        r3 = ref8(xa3, xb3, xc3);
        dones = 0;
        done_at = -1;
        @(negedge clk);
        bus8.start = 1'b1; bus8.A = xa1; bus8.B = xb1; bus8.Cin = xc1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (bus8.done) begin
                dones++;
                done_at = e - 1;
            end
            bus8.start = (e == 3) || (e == 9) || (e == 10);
            bus8.A   = (e == 10) ? xa3 : xa2;
            bus8.B   = (e == 10) ? xb3 : xb2;
            bus8.Cin = (e == 10) ? xc3 : xc2;
        end
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        check("ignored starts done count", 64'(dones), 64'd1);
        check("ignored starts done edge", 64'(done_at), 64'd8);
        check("ignored starts S", 64'(bus8.S), 64'(r1[7:0]));
        check("ignored starts Cout", 64'(bus8.Cout), 64'(r1[8]));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("edge10 accept busy", 64'(bus8.busy), 64'd1);
        end
        @(negedge clk);
        check("edge10 done", 64'(bus8.done), 64'd1);
        check("edge10 S", 64'(bus8.S), 64'(r3[7:0]));
        check("edge10 Cout", 64'(bus8.Cout), 64'(r3[8]));

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        bus8.start = 1'b1; bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.Cin = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset busy", 64'(bus8.busy), 64'd0);
        check("async reset done", 64'(bus8.done), 64'd0);
        check("async reset S", 64'(bus8.S), 64'd0);
        check("async reset Cout", 64'(bus8.Cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done) dones++;
        end
        check("no done after reset", 64'(dones), 64'd0);
        check("idle after reset", 64'(bus8.busy), 64'd0);
        prev_s = 8'h00;
        prev_c = 1'b0;
        run8(8'h12, 8'h34, 1'b1, "post-reset");

        // N=1: every operand combination
        for (int v = 0; v < 8; v++) begin
            a1 = v[2];
            b1 = v[1];
            c1 = v[0];
            e1 = 2'(int'(a1) + int'(b1) + int'(c1));
            @(negedge clk);
            bus1.start = 1'b1; bus1.A = a1; bus1.B = b1; bus1.Cin = c1;
            @(posedge clk);
            #1;
            bus1.start = 1'b0;
            bus1.A = 1'($urandom); bus1.B = 1'($urandom); bus1.Cin = 1'($urandom);
            @(negedge clk);
            check("n1 busy", 64'(bus1.busy), 64'd1);
            check("n1 done low in run", 64'(bus1.done), 64'd0);
            @(negedge clk);
            check("n1 done", 64'(bus1.done), 64'd1);
            check("n1 sum", 64'({bus1.Cout, bus1.S}), 64'(e1));
            @(negedge clk);
            check("n1 done one cycle", 64'(bus1.done), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
